// File: rtl/cart_loader_ctrl.sv
// ROM download sequencer: moves HPS ioctl bytes into the SDRAM toggle-handshake write port,
// builds the cartridge size masks, detects a copier header and maps system ROM reads.
module cart_loader_ctrl #(
    parameter int         AW        = 22,
    parameter int         HDR_BYTES = 512,
    parameter logic [4:0] GG_INDEX  = 5'd2
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          ioctl_wait,
    output logic [AW-1:0] sd_waddr,
    output logic [7:0]    sd_wdata,
    output logic          sd_we,
    input  logic          sd_we_ack,
    input  logic [AW-1:0] cpu_a,
    output logic [AW-1:0] rom_raddr,
    output logic          gg,
    output logic          hdr,
    output logic          cart_ready
);

    localparam int            HB    = $clog2(HDR_BYTES);
    localparam logic [AW-1:0] HDR_A = AW'(HDR_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_XFER     = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t        state_r;
    logic          dl_prev_r;
    logic [AW-1:0] mask_r;
    logic [AW-1:0] mask_h_r;
    logic [AW-1:0] last_addr_r;

    logic          dl_rise_s;
    logic          dl_fall_s;
    logic          ack_done_s;
    logic [AW-1:0] end_addr_s;
    logic          unused_s;

    // Edge detect on the download strobe and handshake completion.
    always_comb begin
        dl_rise_s  = ioctl_download & ~dl_prev_r;
        dl_fall_s  = ~ioctl_download & dl_prev_r;
        ack_done_s = (sd_we_ack == sd_we);
        // One past the last byte written: a size that is an odd multiple of HDR_BYTES
        // (e.g. 1536 = 1024 + 512) has this bit set. Re-arm seeds last_addr with all ones
        // so an empty image yields zero here.
        end_addr_s = last_addr_r + AW'(1);
        unused_s   = ^{ioctl_index[7:5], end_addr_s};
    end

    // Download sequencer with registered handshake, mask and status outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            dl_prev_r   <= 1'b0;
            mask_r      <= '0;
            mask_h_r    <= '0;
            last_addr_r <= '0;
            ioctl_wait  <= 1'b0;
            sd_waddr    <= '0;
            sd_wdata    <= 8'h00;
            sd_we       <= 1'b0;
            gg          <= 1'b0;
            hdr         <= 1'b0;
            cart_ready  <= 1'b0;
        end else begin
            dl_prev_r <= ioctl_download;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (state_r == ST_DONE) begin
                        cart_ready <= 1'b1;
                    end
                    if (dl_rise_s) begin
                        mask_r      <= '0;
                        mask_h_r    <= '0;
                        last_addr_r <= '1;
                        hdr         <= 1'b0;
                        cart_ready  <= 1'b0;
                        gg          <= (ioctl_index[4:0] == GG_INDEX);
                        state_r     <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (dl_fall_s) begin
                        hdr     <= end_addr_s[HB];
                        state_r <= ST_DONE;
                    end else if (ioctl_wr) begin
                        sd_waddr    <= ioctl_addr;
                        sd_wdata    <= ioctl_dout;
                        sd_we       <= ~sd_we;
                        ioctl_wait  <= 1'b1;
                        last_addr_r <= ioctl_addr;
                        mask_r      <= mask_r | ioctl_addr;
                        if (ioctl_addr >= HDR_A) begin
                            mask_h_r <= mask_h_r | (ioctl_addr - HDR_A);
                        end
                        state_r <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    // Strobes arriving here are ignored; a download that ended meanwhile
                    // is finished only once the outstanding write is acknowledged.
                    if (ack_done_s) begin
                        ioctl_wait <= 1'b0;
                        if (!ioctl_download) begin
                            hdr     <= end_addr_s[HB];
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_XFER;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // ROM read mapping; the header-skip offset wraps within the AW-bit space.
    always_comb begin
        if (hdr) begin
            rom_raddr = (cpu_a & mask_h_r) + HDR_A;
        end else begin
            rom_raddr = cpu_a & mask_r;
        end
    end

endmodule

// File: tb/tb_cart_loader_ctrl.sv
// Bench for cart_loader_ctrl: table of download images plus hand-written handshake corner cases,
// with an SDRAM ack responder and a write scoreboard.
module tb_cart_loader_ctrl;

    localparam int AW = 22;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b1;
    logic          ioctl_download = 1'b0;
    logic [7:0]    ioctl_index = 8'h00;
    logic          ioctl_wr = 1'b0;
    logic [AW-1:0] ioctl_addr = '0;
    logic [7:0]    ioctl_dout = 8'h00;
    logic          sd_we_ack = 1'b0;
    logic [AW-1:0] cpu_a = '0;
    logic          ioctl_wait;
    logic [AW-1:0] sd_waddr;
    logic [7:0]    sd_wdata;
    logic          sd_we;
    logic [AW-1:0] rom_raddr;
    logic          gg;
    logic          hdr;
    logic          cart_ready;

    cart_loader_ctrl #(.AW(AW), .HDR_BYTES(512), .GG_INDEX(5'd2)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .sd_waddr(sd_waddr),
        .sd_wdata(sd_wdata), .sd_we(sd_we), .sd_we_ack(sd_we_ack), .cpu_a(cpu_a),
        .rom_raddr(rom_raddr), .gg(gg), .hdr(hdr), .cart_ready(cart_ready)
    );

    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // SDRAM responder: echoes the request toggle ack_delay cycles after it changes.
    int ack_delay = 3;
    int ack_cnt = 0;
    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sd_we_ack <= 1'b0;
            ack_cnt   <= 0;
        end else if (sd_we !== sd_we_ack) begin
            if (ack_cnt + 1 >= ack_delay) begin
                sd_we_ack <= sd_we;
                ack_cnt   <= 0;
            end else begin
                ack_cnt <= ack_cnt + 1;
            end
        end
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    logic prev_we = 1'b0;
    int   toggles = 0;
    int   wait_cnt = 0;

    // Scoreboard: every request toggle must carry the next expected byte.
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            prev_we = 1'b0;
        end else begin
            if (ioctl_wait) wait_cnt++;
            if (sd_we !== prev_we) begin
                prev_we = sd_we;
                toggles++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_toggle: addr 0x%0h data 0x%0h, expected no write", sd_waddr, sd_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sd_waddr", 32'(sd_waddr), 32'(mon_e.a));
                    chk("sd_wdata", 32'(sd_wdata), 32'(mon_e.d));
                end
            end
        end
    end

    task automatic wait_idle();
        int b = 0;
        while (ioctl_wait && b < 200) begin
            @(negedge clk_sys);
            b++;
        end
        chk("wait_release", 32'(ioctl_wait), 32'd0);
    endtask

    task automatic send_byte(input logic [AW-1:0] a, input logic [7:0] d);
        wait_idle();
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        exp_q.push_back(wr_t'{a: a, d: d});
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        @(negedge clk_sys);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        wait_cnt = 0;
        toggles  = 0;
        chk("ready_drop_on_arm", 32'(cart_ready), 32'd0);
    endtask

    task automatic end_dl();
        int b = 0;
        wait_idle();
        ioctl_download = 1'b0;
        while (!cart_ready && b < 100) begin
            @(negedge clk_sys);
            b++;
        end
        chk("cart_ready", 32'(cart_ready), 32'd1);
    endtask

    task automatic map_chk(input string name, input logic [AW-1:0] a, input logic [AW-1:0] exp);
        cpu_a = a;
        #1;
        chk(name, 32'(rom_raddr), 32'(exp));
    endtask

    typedef struct {
        logic [7:0]    idx;
        int            n;
        logic [AW-1:0] a;
        logic [AW-1:0] exp_r;
        logic          exp_gg;
        logic          exp_hdr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int b;
        vecs[0] = '{idx: 8'h00, n: 1024, a: 22'h001234, exp_r: 22'h000234, exp_gg: 1'b0, exp_hdr: 1'b0};
        vecs[1] = '{idx: 8'h00, n: 1536, a: 22'h000000, exp_r: 22'h000200, exp_gg: 1'b0, exp_hdr: 1'b1};
        vecs[2] = '{idx: 8'h02, n: 1536, a: 22'h000401, exp_r: 22'h000201, exp_gg: 1'b1, exp_hdr: 1'b1};
        vecs[3] = '{idx: 8'h01, n: 256,  a: 22'h003ABC, exp_r: 22'h0000BC, exp_gg: 1'b0, exp_hdr: 1'b0};
        vecs[4] = '{idx: 8'h22, n: 1024, a: 22'h3FFFFF, exp_r: 22'h0003FF, exp_gg: 1'b1, exp_hdr: 1'b0};
        vecs[5] = '{idx: 8'h00, n: 0,    a: 22'h3FFFFF, exp_r: 22'h000000, exp_gg: 1'b0, exp_hdr: 1'b0};
        vecs[6] = '{idx: 8'h00, n: 2560, a: 22'h3FFFFF, exp_r: 22'h0009FF, exp_gg: 1'b0, exp_hdr: 1'b1};

        // Reset values.
        #2 reset_n = 1'b0;
        #1;
        chk("rst_ioctl_wait", 32'(ioctl_wait), 32'd0);
        chk("rst_sd_we", 32'(sd_we), 32'd0);
        chk("rst_sd_waddr", 32'(sd_waddr), 32'd0);
        chk("rst_sd_wdata", 32'(sd_wdata), 32'd0);
        chk("rst_gg", 32'(gg), 32'd0);
        chk("rst_hdr", 32'(hdr), 32'd0);
        chk("rst_cart_ready", 32'(cart_ready), 32'd0);
        map_chk("rst_rom_raddr", 22'h3FFFFF, 22'h000000);
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;

        // Linear images from the table, ack three cycles after each toggle.
        for (int v = 0; v < 7; v++) begin
            start_dl(vecs[v].idx);
            for (int i = 0; i < vecs[v].n; i++) send_byte(AW'(i), 8'(i) ^ 8'h5A);
            end_dl();
            chk("toggles", 32'(toggles), 32'(vecs[v].n));
            chk("wait_cycles", 32'(wait_cnt), 32'(4 * vecs[v].n));
            chk("sb_drained", 32'(exp_q.size()), 32'd0);
            chk("gg", 32'(gg), 32'(vecs[v].exp_gg));
            chk("hdr", 32'(hdr), 32'(vecs[v].exp_hdr));
            map_chk("rom_raddr", vecs[v].a, vecs[v].exp_r);
        end

        // Sparse image: a byte below the header boundary must not reach mask_h.
        start_dl(8'h00);
        send_byte(22'h0001FF, 8'h11);
        send_byte(22'h000600, 8'h22);
        end_dl();
        chk("sparse_hdr", 32'(hdr), 32'd1);
        map_chk("sparse_map", 22'h3FFFFF, 22'h000600);

        // Header offset wraps at the top of the address space.
        start_dl(8'h00);
        send_byte(22'h3FFFFF, 8'h33);
        send_byte(22'h3FFDFF, 8'h44);
        end_dl();
        chk("wrap_hdr", 32'(hdr), 32'd1);
        map_chk("wrap_map_top", 22'h3FFFFF, 22'h0001FF);
        map_chk("wrap_map_low", 22'h000100, 22'h000300);

        // Download ends while the last write is still waiting for a slow ack.
        ack_delay = 20;
        start_dl(8'h00);
        for (int i = 0; i < 3; i++) send_byte(AW'(i), 8'hC0 + 8'(i));
        send_byte(22'h000003, 8'hC3);
        ioctl_download = 1'b0;
        b = 0;
        while (!cart_ready && b < 100) begin
            @(negedge clk_sys);
            b++;
        end
        chk("defer_ready", 32'(cart_ready), 32'd1);
        chk("defer_latency_ge19", 32'(b >= 19), 32'd1);
        chk("defer_ack_done", 32'(sd_we_ack), 32'(sd_we));
        chk("defer_sb_drained", 32'(exp_q.size()), 32'd0);
        chk("defer_last_addr", 32'(sd_waddr), 32'h3);
        map_chk("defer_map", 22'h3FFFFF, 22'h000003);

        // A strobe during ioctl_wait is ignored.
        ack_delay = 3;
        start_dl(8'h00);
        send_byte(22'h000010, 8'hA1);
        chk("viol_wait_high", 32'(ioctl_wait), 32'd1);
        ioctl_wr   = 1'b1;
        ioctl_addr = 22'h0003F0;
        ioctl_dout = 8'hEE;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        end_dl();
        chk("viol_toggles", 32'(toggles), 32'd1);
        chk("viol_wdata", 32'(sd_wdata), 32'hA1);
        chk("viol_waddr", 32'(sd_waddr), 32'h10);
        map_chk("viol_map", 22'h3FFFFF, 22'h000010);

        // Reset in the middle of a pending write, then a fresh download.
        ack_delay = 20;
        start_dl(8'h00);
        send_byte(22'h000005, 8'h77);
        chk("mid_wait_high", 32'(ioctl_wait), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_ioctl_wait", 32'(ioctl_wait), 32'd0);
        chk("arst_sd_we", 32'(sd_we), 32'd0);
        chk("arst_cart_ready", 32'(cart_ready), 32'd0);
        chk("arst_hdr", 32'(hdr), 32'd0);
        exp_q.delete();
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        reset_n   = 1'b1;
        ack_delay = 3;
        start_dl(8'h02);
        for (int i = 0; i < 64; i++) send_byte(AW'(i), 8'(i) ^ 8'h3C);
        end_dl();
        chk("post_rst_toggles", 32'(toggles), 32'd64);
        chk("post_rst_gg", 32'(gg), 32'd1);
        chk("post_rst_hdr", 32'(hdr), 32'd0);
        map_chk("post_rst_map", 22'h3FFFFF, 22'h00003F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
